// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin 8:1 mux arbiter with bounded grants, one idle cycle between owners
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] x,
  output logic       EN,
  output logic [7:0] gnt,
  output logic [2:0] last
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [2:0] x_n, last_n, pick, idx;
  logic [3:0] cnt, cnt_n;
  logic rel;
  // descending scan so the requester closest after last wins
  always_comb begin
    pick = x;
    idx = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = last + 3'(k + 1);
      pick = req[idx] ? idx : pick;
    end
  end
  assign rel = done | ~req[x] | (cnt == 4'(HOLD_MAX - 1));
  always_comb begin
    state_n = state;
    x_n = x;
    last_n = last;
    cnt_n = cnt;
    if (state == IDLE) begin
      if (|req) begin
        state_n = GRANT;
        x_n = pick;
        cnt_n = '0;
      end
    end else if (rel) begin
      state_n = IDLE;
      last_n = x;
    end else
      cnt_n = cnt + 4'd1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      x <= '0;
      last <= 3'd7;
      cnt <= '0;
      EN <= 1'b0;
      gnt <= '0;
    end else begin
      state <= state_n;
      x <= x_n;
      last <= last_n;
      cnt <= cnt_n;
      EN <= state_n == GRANT;
      gnt <= (state_n == GRANT) ? 8'h01 << x_n : 8'h00;
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed table and sequence checks of the round-robin mux arbiter
module tb_mux_rr_arbiter;
  logic clk = 0, rst = 1, done = 0;
  logic [7:0] req = 0;
  logic [2:0] x, last, x1, last1;
  logic en, en1;
  logic [7:0] gnt, gnt1;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  mux_rr_arbiter #(.HOLD_MAX(8)) dut (.clk(clk), .rst(rst), .req(req), .done(done), .x(x), .EN(en), .gnt(gnt), .last(last));
  mux_rr_arbiter #(.HOLD_MAX(1)) dut1 (.clk(clk), .rst(rst), .req(req), .done(done), .x(x1), .EN(en1), .gnt(gnt1), .last(last1));
  typedef struct packed {
    logic [7:0] req;
    logic       done;
    logic       en;
    logic [2:0] x;
    logic [7:0] gnt;
    logic [2:0] last;
  } vec_t;
  vec_t v[13];
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string n, input logic e, input logic [2:0] ex, input logic [7:0] eg, input logic [2:0] el);
    chk({n, ".EN"}, {7'b0, en}, {7'b0, e});
    chk({n, ".x"}, {5'b0, x}, {5'b0, ex});
    chk({n, ".gnt"}, gnt, eg);
    chk({n, ".last"}, {5'b0, last}, {5'b0, el});
  endtask
  // every-cycle invariants: gnt matches x/EN, no owner change or overlong run without a gap
  logic pen = 0, pen1 = 0;
  logic [2:0] px = 0;
  int run = 0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_vs_x", gnt, en ? 8'h01 << x : 8'h00);
      chk("gnt1_vs_x1", gnt1, en1 ? 8'h01 << x1 : 8'h00);
      chk("x_change_no_gap", {7'b0, pen && en && (x != px)}, 8'h00);
      chk("max_run", {7'b0, en && (run >= 8)}, 8'h00);
      chk("hold1_gap", {7'b0, pen1 && en1}, 8'h00);
    end
    run = en ? run + 1 : 0;
    pen = en;
    pen1 = en1;
    px = x;
  end
  initial begin
    logic [2:0] gx;
    v[0]  = {8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 3'd0};
    v[1]  = {8'h00, 1'b0, 1'b0, 3'd5, 8'h00, 3'd5};
    v[2]  = {8'h09, 1'b0, 1'b1, 3'd0, 8'h01, 3'd5};
    v[3]  = {8'h09, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0};
    v[4]  = {8'h09, 1'b0, 1'b1, 3'd3, 8'h08, 3'd0};
    v[5]  = {8'h00, 1'b0, 1'b0, 3'd3, 8'h00, 3'd3};
    v[6]  = {8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 3'd3};
    v[7]  = {8'hF4, 1'b0, 1'b1, 3'd2, 8'h04, 3'd3};
    v[8]  = {8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 3'd3};
    v[9]  = {8'h04, 1'b1, 1'b0, 3'd2, 8'h00, 3'd2};
    v[10] = {8'h04, 1'b1, 1'b1, 3'd2, 8'h04, 3'd2};
    v[11] = {8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 3'd2};
    v[12] = {8'h00, 1'b0, 1'b0, 3'd2, 8'h00, 3'd2};
    tick;
    tick;
    outs("reset", 0, 0, 8'h00, 7);
    rst = 0;
    req = 8'h01;
    tick;
    outs("basic_grant", 1, 0, 8'h01, 7);
    chk("hold1_grant", {7'b0, en1}, 8'h01);
    for (int i = 1; i < 8; i++) begin
      tick;
      outs("basic_hold", 1, 0, 8'h01, 7);
      if (i == 1) chk("hold1_release", {4'b0, en1, last1}, 8'h00);
      if (i == 2) chk("hold1_regrant", {7'b0, en1}, 8'h01);
    end
    tick;
    outs("basic_gap", 0, 0, 8'h00, 0);
    tick;
    outs("basic_regrant", 1, 0, 8'h01, 0);
    req = 8'h00;
    tick;
    outs("basic_drop", 0, 0, 8'h00, 0);
    rst = 1;
    tick;
    rst = 0;
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      gx = 3'(g);
      tick;
      outs("rot_grant", 1, gx, 8'h01 << gx, 3'(g - 1));
      for (int c = 1; c < 8; c++) begin
        tick;
        outs("rot_hold", 1, gx, 8'h01 << gx, 3'(g - 1));
      end
      tick;
      outs("rot_gap", 0, gx, 8'h00, gx);
    end
    req = 8'h00;
    tick;
    outs("rot_idle", 0, 0, 8'h00, 0);
    for (int i = 0; i < 13; i++) begin
      req = v[i].req;
      done = v[i].done;
      tick;
      outs($sformatf("vec%0d", i), v[i].en, v[i].x, v[i].gnt, v[i].last);
    end
    req = 8'h10;
    tick;
    outs("pre_rst", 1, 4, 8'h10, 2);
    #2;
    rst = 1;
    #1;
    outs("async_rst", 0, 0, 8'h00, 7);
    rst = 0;
    tick;
    outs("post_rst", 1, 4, 8'h10, 7);
    req = 8'h00;
    tick;
    outs("post_rst_rel", 0, 4, 8'h00, 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
